// File: rtl/ring_phase_decoder_if.sv
// Bundle between a ring-counter phase source and the ring_phase_decoder monitor.
// The source drives the phase vector and error clear; the decoder returns the status.
interface ring_phase_decoder_if #(
    parameter int N     = 4,
    parameter int REV_W = 8
) ();
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]     ring_in;
    logic             clr_err;
    logic [PW-1:0]    phase_idx;
    logic             phase_vld;
    logic             locked;
    logic             rev_tick;
    logic [REV_W-1:0] rev_cnt;
    logic             err_onehot;
    logic             err_seq;

    modport master (
        output ring_in, clr_err,
        input  phase_idx, phase_vld, locked, rev_tick, rev_cnt, err_onehot, err_seq
    );

    modport slave (
        input  ring_in, clr_err,
        output phase_idx, phase_vld, locked, rev_tick, rev_cnt, err_onehot, err_seq
    );
endinterface

// File: rtl/ring_phase_decoder.sv
// Health monitor for an N-phase one-hot ring: encodes the phase, checks single-step
// advance, declares lock, counts revolutions and keeps sticky corruption/sequence flags.
module ring_phase_decoder #(
    parameter int N        = 4,
    parameter int LOCK_LEN = 4,
    parameter int REV_W    = 8
) (
    input  logic               clk,
    input  logic               n_rst,
    ring_phase_decoder_if.slave bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (LOCK_LEN > 1) ? $clog2(LOCK_LEN) : 1;

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] TRACK  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam logic [PW-1:0] LAST_IDX  = PW'(N - 1);
    localparam logic [CW-1:0] LAST_GOOD = CW'(LOCK_LEN - 1);

    // Phases whose index has bit b set; OR-ing those ring bits yields index bit b.
    function automatic logic [N-1:0] idx_bit_mask(input int b);
        logic [N-1:0] m;
        m = '0;
        for (int k = 0; k < N; k++) begin
            m[k] = ((k >> b) & 1) != 0;
        end
        return m;
    endfunction

    logic [1:0]       state_reg, state_next;
    logic [CW-1:0]    good_reg, good_next;
    logic [PW-1:0]    prev_idx_reg, prev_idx_next;
    logic [PW-1:0]    phase_idx_reg, phase_idx_next;
    logic             phase_vld_reg, phase_vld_next;
    logic             locked_reg, locked_next;
    logic             rev_tick_reg, rev_tick_next;
    logic [REV_W-1:0] rev_cnt_reg, rev_cnt_next;
    logic             err_onehot_reg, err_onehot_next;
    logic             err_seq_reg, err_seq_next;

    logic [PW-1:0]    enc_idx;
    logic [PW-1:0]    step_idx;
    logic             one_hot;
    logic             legal;

    genvar gi;
    generate
        for (gi = 0; gi < PW; gi++) begin : g_enc
            localparam logic [N-1:0] MASK = idx_bit_mask(gi);
            assign enc_idx[gi] = |(bus.ring_in & MASK);
        end
    endgenerate

    assign one_hot  = (bus.ring_in != '0) && ((bus.ring_in & (bus.ring_in - N'(1))) == '0);
    assign step_idx = (prev_idx_reg == LAST_IDX) ? '0 : prev_idx_reg + PW'(1);
    assign legal    = one_hot && (enc_idx == step_idx);

    always_comb begin
        state_next      = state_reg;
        good_next       = good_reg;
        prev_idx_next   = prev_idx_reg;
        phase_idx_next  = phase_idx_reg;
        phase_vld_next  = one_hot;
        rev_tick_next   = 1'b0;
        rev_cnt_next    = rev_cnt_reg;
        err_onehot_next = bus.clr_err ? 1'b0 : err_onehot_reg;
        err_seq_next    = bus.clr_err ? 1'b0 : err_seq_reg;

        if (one_hot) begin
            phase_idx_next = enc_idx;
            prev_idx_next  = enc_idx;
        end

        // Error sets are evaluated after the clear so a coincident error wins.
        case (state_reg)
            HUNT: begin
                if (one_hot) begin
                    state_next = TRACK;
                    good_next  = '0;
                end
            end
            TRACK: begin
                if (!one_hot) begin
                    err_onehot_next = 1'b1;
                    state_next      = HUNT;
                end else if (legal) begin
                    if (good_reg == LAST_GOOD) begin
                        state_next = LOCKED;
                    end else begin
                        good_next = good_reg + CW'(1);
                    end
                end else begin
                    good_next = '0;
                end
            end
            LOCKED: begin
                if (!one_hot) begin
                    err_onehot_next = 1'b1;
                    state_next      = HUNT;
                end else if (!legal) begin
                    err_seq_next = 1'b1;
                    state_next   = TRACK;
                    good_next    = '0;
                end else if (enc_idx == '0) begin
                    rev_tick_next = 1'b1;
                    rev_cnt_next  = rev_cnt_reg + REV_W'(1);
                end
            end
            default: begin
                state_next = HUNT;
                good_next  = '0;
            end
        endcase

        locked_next = (state_next == LOCKED);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg      <= HUNT;
            good_reg       <= '0;
            prev_idx_reg   <= '0;
            phase_idx_reg  <= '0;
            phase_vld_reg  <= 1'b0;
            locked_reg     <= 1'b0;
            rev_tick_reg   <= 1'b0;
            rev_cnt_reg    <= '0;
            err_onehot_reg <= 1'b0;
            err_seq_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            good_reg       <= good_next;
            prev_idx_reg   <= prev_idx_next;
            phase_idx_reg  <= phase_idx_next;
            phase_vld_reg  <= phase_vld_next;
            locked_reg     <= locked_next;
            rev_tick_reg   <= rev_tick_next;
            rev_cnt_reg    <= rev_cnt_next;
            err_onehot_reg <= err_onehot_next;
            err_seq_reg    <= err_seq_next;
        end
    end

    assign bus.phase_idx  = phase_idx_reg;
    assign bus.phase_vld  = phase_vld_reg;
    assign bus.locked     = locked_reg;
    assign bus.rev_tick   = rev_tick_reg;
    assign bus.rev_cnt    = rev_cnt_reg;
    assign bus.err_onehot = err_onehot_reg;
    assign bus.err_seq    = err_seq_reg;
endmodule

// File: tb/tb_ring_phase_decoder.sv
// Directed bench for ring_phase_decoder: a run-length model of lock/revolution/error
// behaviour is compared every cycle, with literal expectations at key edges.
module tb_ring_phase_decoder;
    localparam int N        = 4;
    localparam int LOCK_LEN = 4;
    localparam int REV_W    = 2;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    ring_phase_decoder_if #(.N(N), .REV_W(REV_W)) bus ();

    ring_phase_decoder #(.N(N), .LOCK_LEN(LOCK_LEN), .REV_W(REV_W)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;
    int p = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_run = -1 when no valid anchor, else number of legal steps since anchor.
    int m_run = -1;
    int m_prev = 0;
    int m_idx = 0;
    int m_rev = 0;
    bit m_vld = 0, m_tick = 0, m_eo = 0, m_es = 0;

    function automatic int onehot_pos(input logic [N-1:0] v);
        if ($countones(v) != 1) return -1;
        for (int k = 0; k < N; k++) if (v[k]) return k;
        return -1;
    endfunction

    always @(posedge clk or negedge n_rst) begin
        int pos;
        bit was_locked;
        if (!n_rst) begin
            m_run = -1; m_prev = 0; m_idx = 0; m_rev = 0;
            m_vld = 0; m_tick = 0; m_eo = 0; m_es = 0;
        end else begin
            pos = onehot_pos(bus.ring_in);
            was_locked = (m_run >= LOCK_LEN);
            m_tick = 0;
            if (bus.clr_err) begin
                m_eo = 0;
                m_es = 0;
            end
            if (pos < 0) begin
                m_vld = 0;
                if (m_run >= 0) m_eo = 1;
                m_run = -1;
            end else begin
                m_vld = 1;
                m_idx = pos;
                if (m_run < 0) begin
                    m_run = 0;
                end else if (pos == (m_prev + 1) % N) begin
                    if (was_locked && pos == 0) begin
                        m_tick = 1;
                        m_rev = (m_rev + 1) % (1 << REV_W);
                    end
                    if (m_run < LOCK_LEN) m_run++;
                end else begin
                    if (was_locked) m_es = 1;
                    m_run = 0;
                end
                m_prev = pos;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("model_phase_idx", 32'(bus.phase_idx), 32'(m_idx));
            chk("model_phase_vld", 32'(bus.phase_vld), 32'(m_vld));
            chk("model_locked", 32'(bus.locked), 32'(m_run >= LOCK_LEN));
            chk("model_rev_tick", 32'(bus.rev_tick), 32'(m_tick));
            chk("model_rev_cnt", 32'(bus.rev_cnt), 32'(m_rev));
            chk("model_err_onehot", 32'(bus.err_onehot), 32'(m_eo));
            chk("model_err_seq", 32'(bus.err_seq), 32'(m_es));
        end
    end

    task automatic drive(input logic [N-1:0] v, input logic clr);
        @(negedge clk);
        bus.ring_in = v;
        bus.clr_err = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic rot(input logic clr);
        logic [N-1:0] v;
        v = '0;
        v[p] = 1'b1;
        p = (p + 1) % N;
        drive(v, clr);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_phase_idx"}, 32'(bus.phase_idx), 0);
        chk({tag, "_phase_vld"}, 32'(bus.phase_vld), 0);
        chk({tag, "_locked"}, 32'(bus.locked), 0);
        chk({tag, "_rev_tick"}, 32'(bus.rev_tick), 0);
        chk({tag, "_rev_cnt"}, 32'(bus.rev_cnt), 0);
        chk({tag, "_err_onehot"}, 32'(bus.err_onehot), 0);
        chk({tag, "_err_seq"}, 32'(bus.err_seq), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ring_in = '0;
        bus.clr_err = 1'b0;
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_en = 1'b1;
        chk_all_zero("reset");
        @(negedge clk);
        n_rst = 1'b1;

        // Clean rotation from the first edge
        for (int e = 1; e <= 13; e++) begin
            rot(1'b0);
            $display("rot edge %0d idx=%0d locked=%0d tick=%0d rev=%0d", e, bus.phase_idx, bus.locked, bus.rev_tick, bus.rev_cnt);
            if (e == 1) begin
                chk("first_vld", 32'(bus.phase_vld), 1);
                chk("first_idx", 32'(bus.phase_idx), 0);
            end
            if (e == 4) chk("lock_e4", 32'(bus.locked), 0);
            if (e == 5) chk("lock_e5", 32'(bus.locked), 1);
            if (e == 5) chk("no_tick_on_lock", 32'(bus.rev_tick), 0);
            if (e == 9) begin
                chk("tick_e9", 32'(bus.rev_tick), 1);
                chk("rev_e9", 32'(bus.rev_cnt), 1);
            end
            if (e == 10) chk("tick_e10", 32'(bus.rev_tick), 0);
            if (e == 13) begin
                chk("rev_e13", 32'(bus.rev_cnt), 2);
                chk("clean_err_onehot", 32'(bus.err_onehot), 0);
                chk("clean_err_seq", 32'(bus.err_seq), 0);
            end
        end

        // Zero-hot glitch while locked
        drive(4'b0000, 1'b0);
        $display("glitch 0000 eo=%0d locked=%0d vld=%0d idx=%0d", bus.err_onehot, bus.locked, bus.phase_vld, bus.phase_idx);
        chk("glitch_err_onehot", 32'(bus.err_onehot), 1);
        chk("glitch_locked", 32'(bus.locked), 0);
        chk("glitch_vld", 32'(bus.phase_vld), 0);
        chk("glitch_idx_held", 32'(bus.phase_idx), 0);
        for (int k = 1; k <= 5; k++) begin
            rot(1'b0);
            $display("relock sample %0d locked=%0d", k, bus.locked);
            if (k == 4) chk("relock_k4", 32'(bus.locked), 0);
            if (k == 5) begin
                chk("relock_k5", 32'(bus.locked), 1);
                chk("err_onehot_sticky", 32'(bus.err_onehot), 1);
            end
        end
        rot(1'b1);
        $display("clr_err eo=%0d", bus.err_onehot);
        chk("clr_err_onehot", 32'(bus.err_onehot), 0);

        // Skip from idx 1 to idx 3 while locked
        repeat (3) rot(1'b0);
        chk("pre_skip_locked", 32'(bus.locked), 1);
        chk("pre_skip_idx", 32'(bus.phase_idx), 1);
        drive(4'b1000, 1'b0);
        $display("skip 1000 es=%0d locked=%0d idx=%0d", bus.err_seq, bus.locked, bus.phase_idx);
        chk("skip_err_seq", 32'(bus.err_seq), 1);
        chk("skip_locked", 32'(bus.locked), 0);
        chk("skip_idx", 32'(bus.phase_idx), 3);
        p = 0;
        for (int k = 1; k <= 4; k++) begin
            rot(1'b0);
            $display("post-skip step %0d locked=%0d", k, bus.locked);
            if (k == 3) chk("skip_relock_k3", 32'(bus.locked), 0);
            if (k == 4) chk("skip_relock_k4", 32'(bus.locked), 1);
        end

        // Held phase while locked
        rot(1'b1);
        chk("clr_err_seq", 32'(bus.err_seq), 0);
        rot(1'b0);
        rot(1'b0);
        drive(4'b0100, 1'b0);
        $display("hold 0100 es=%0d locked=%0d", bus.err_seq, bus.locked);
        chk("hold_err_seq", 32'(bus.err_seq), 1);
        chk("hold_locked", 32'(bus.locked), 0);

        // Clear coincident with a two-hot sample in TRACK
        drive(4'b0110, 1'b1);
        $display("0110+clr eo=%0d es=%0d", bus.err_onehot, bus.err_seq);
        chk("set_wins_err_onehot", 32'(bus.err_onehot), 1);
        chk("set_wins_err_seq_cleared", 32'(bus.err_seq), 0);
        drive(4'b0000, 1'b1);
        $display("clr only eo=%0d", bus.err_onehot);
        chk("clr_only_err_onehot", 32'(bus.err_onehot), 0);

        // Asynchronous reset mid-revolution
        p = 0;
        repeat (7) rot(1'b0);
        chk("pre_reset_locked", 32'(bus.locked), 1);
        #1;
        bus.ring_in = '0;
        bus.clr_err = 1'b0;
        n_rst = 1'b0;
        #1;
        $display("async reset locked=%0d rev=%0d", bus.locked, bus.rev_cnt);
        chk_all_zero("async_reset");
        @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;

        // First sample after reset, then lock and four revolutions with REV_W=2
        p = 2;
        rot(1'b0);
        chk("post_reset_err_onehot", 32'(bus.err_onehot), 0);
        chk("post_reset_err_seq", 32'(bus.err_seq), 0);
        chk("post_reset_idx", 32'(bus.phase_idx), 2);
        repeat (3) rot(1'b0);
        chk("post_reset_lock4", 32'(bus.locked), 0);
        rot(1'b0);
        chk("post_reset_lock5", 32'(bus.locked), 1);
        rot(1'b0);
        for (int r = 1; r <= 4; r++) begin
            rot(1'b0);
            $display("revolution %0d tick=%0d rev=%0d", r, bus.rev_tick, bus.rev_cnt);
            chk("rev_tick", 32'(bus.rev_tick), 1);
            chk("rev_cnt_wrap", 32'(bus.rev_cnt), 32'(r % 4));
            repeat (3) rot(1'b0);
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
